// File: rtl/piso_256bit_pkg.sv
//==============================================================================
// Module      : piso_pkg
// Description : Shared constants, state encoding and slot helper for the
//               256-bit word to 10-bit sample unpacker.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package piso_pkg;

   localparam int SLOTS    = 25;
   localparam int SAMPLE_W = 10;
   localparam int FLAG_W   = 6;
   localparam int PIX_W    = 16;
   localparam int DATA_W   = 250;
   localparam int WORD_W   = 256;
   localparam int SLOT_W   = 5;
   localparam int LSB_W    = 9;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
   localparam logic [PIX_W-1:0]  SLOTS_PIX = PIX_W'(SLOTS);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bit offset of sample slot i inside the data field
   function automatic logic [LSB_W-1:0] slot_lsb(input logic [SLOT_W-1:0] i);
      return LSB_W'(i) * LSB_W'(SAMPLE_W);
   endfunction

endpackage

`default_nettype wire

// File: rtl/piso_256bit.sv
//==============================================================================
// Module      : piso_256bit
// Description : Unpacks 256-bit DDR3 readback words (6-bit frame flag plus
//               25 x 10-bit slots) into a handshaked sample stream with
//               start/end-of-frame markers. Frame-end words carry their
//               samples in the top slots, so the last slot of every word is
//               always slot 24.
//               Optional macro PISO_FLAG_CHECK_EN enables the sticky frame
//               flag consistency checker driving err_flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module piso_256bit
   import piso_pkg::*;
(
   input  logic                clk,
   input  logic                nrst,
   input  logic [PIX_W-1:0]    frame_pixels,
   input  logic [WORD_W-1:0]   word_in,
   input  logic                word_valid,
   output logic                word_ready,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                sample_sof,
   output logic                sample_eof,
   output logic [FLAG_W-1:0]   frame_tag,
   output logic                err_flag,
   input  logic                err_clr
);

   state_t              r_state;
   logic [WORD_W-1:0]   r_word;
   logic [SLOT_W-1:0]   r_slot;
   logic [PIX_W-1:0]    r_cnt;
   logic [PIX_W-1:0]    r_len;

   logic                w_hs_sample;
   logic                w_last_hs;
   logic                w_hs_word;
   logic                w_eof;
   logic [PIX_W-1:0]    w_cnt_next;
   logic [PIX_W-1:0]    w_len_sel;
   logic [PIX_W-1:0]    w_rem;
   logic [SLOT_W-1:0]   w_start;
   logic                w_frame_end;

   assign sample_valid = (r_state == SHIFT);
   assign sample_out   = r_word[slot_lsb(r_slot) +: SAMPLE_W];
   assign w_eof        = (r_cnt == (r_len - PIX_W'(1)));
   assign sample_sof   = sample_valid && (r_cnt == '0);
   assign sample_eof   = sample_valid && w_eof;
   assign frame_tag    = r_word[WORD_W-1 -: FLAG_W];

   assign w_hs_sample  = sample_valid && sample_ready;
   assign w_last_hs    = w_hs_sample && (r_slot == LAST_SLOT);
   // A new word may load in the same cycle the last slot drains (no bubble)
   assign word_ready   = nrst && ((r_state == IDLE) || w_last_hs);
   assign w_hs_word    = word_valid && word_ready;

   // Pixel count after this cycle's handshake, used to size an incoming word
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_hs_sample) begin
         w_cnt_next = w_eof ? '0 : (r_cnt + PIX_W'(1));
      end
      w_len_sel   = (w_cnt_next == '0) ? frame_pixels : r_len;
      w_rem       = w_len_sel - w_cnt_next;
      w_frame_end = (w_rem <= SLOTS_PIX);
      // A zero remainder only arises from an illegal frame length; treat as full
      if ((w_rem >= SLOTS_PIX) || (w_rem == '0)) begin
         w_start = '0;
      end else begin
         w_start = SLOT_W'(SLOTS) - w_rem[SLOT_W-1:0];
      end
   end

   // Main IDLE/SHIFT sequencer: word load, slot advance and pixel counting
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= IDLE;
         r_word  <= '0;
         r_slot  <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_hs_word) begin
            r_word  <= word_in;
            r_slot  <= w_start;
            r_len   <= w_len_sel;
            r_state <= SHIFT;
         end else if (w_hs_sample) begin
            if (r_slot == LAST_SLOT) begin
               r_state <= IDLE;
            end else begin
               r_slot <= r_slot + SLOT_W'(1);
            end
         end
      end
   end

`ifdef PISO_FLAG_CHECK_EN
   logic                r_err;
   logic                r_have_prev;
   logic [FLAG_W-1:0]   r_prev;
   logic [FLAG_W-1:0]   w_flag;
   logic [FLAG_W-1:0]   w_expect;
   logic                w_err_evt;

   assign w_flag   = word_in[WORD_W-1 -: FLAG_W];
   // Flag sequence runs 1..63 then wraps back to 1
   assign w_expect = (r_prev == '1) ? FLAG_W'(1) : (r_prev + FLAG_W'(1));

   // Flag consistency rules evaluated on every accepted word
   always_comb begin
      w_err_evt = 1'b0;
      if (w_hs_word) begin
         if (!w_frame_end && (w_flag != '0)) begin
            w_err_evt = 1'b1;
         end
         if (w_frame_end && (w_flag == '0)) begin
            w_err_evt = 1'b1;
         end
         if (w_frame_end && (w_flag != '0) && r_have_prev && (w_flag != w_expect)) begin
            w_err_evt = 1'b1;
         end
      end
   end

   // Sticky error (event beats clear) and last-seen frame flag tracking
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_err       <= 1'b0;
         r_have_prev <= 1'b0;
         r_prev      <= '0;
      end else begin
         if (w_err_evt) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
         if (w_hs_word && w_frame_end && (w_flag != '0)) begin
            r_prev      <= w_flag;
            r_have_prev <= 1'b1;
         end
      end
   end

   assign err_flag = r_err;
`else
   assign err_flag = err_clr & 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_piso_256bit.sv
//==============================================================================
// Module      : tb_piso_256bit
// Description : Self-checking bench for piso_256bit. A frame packer builds
//               words from random samples and an expected sample queue; the
//               stream is driven with random gaps and backpressure.
//               Honours PISO_FLAG_CHECK_EN for the error-flag scenarios.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_piso_256bit;
   import piso_pkg::*;

   logic                clk = 1'b0;
   logic                nrst;
   logic [PIX_W-1:0]    frame_pixels;
   logic [WORD_W-1:0]   word_in;
   logic                word_valid;
   logic                word_ready;
   logic [SAMPLE_W-1:0] sample_out;
   logic                sample_valid;
   logic                sample_ready;
   logic                sample_sof;
   logic                sample_eof;
   logic [FLAG_W-1:0]   frame_tag;
   logic                err_flag;
   logic                err_clr;

   typedef struct {
      logic [SAMPLE_W-1:0] s;
      logic                sof;
      logic                eof;
      logic [FLAG_W-1:0]   tag;
   } exp_t;

   exp_t                eq[$];
   logic [WORD_W-1:0]   wq[$];
   logic [PIX_W-1:0]    fq[$];

   int n_checks = 0;
   int n_fail   = 0;

   piso_256bit dut (
      .clk          (clk),
      .nrst         (nrst),
      .frame_pixels (frame_pixels),
      .word_in      (word_in),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_sof   (sample_sof),
      .sample_eof   (sample_eof),
      .frame_tag    (frame_tag),
      .err_flag     (err_flag),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pack a frame of n random samples into words: full words of 25, and a
   // final word holding the remainder in the top slots with the frame flag.
   task automatic build_frame(input int n, input logic [FLAG_W-1:0] flag);
      logic [SAMPLE_W-1:0] smp[$];
      logic [WORD_W-1:0]   w;
      exp_t                e;
      int                  left, pos, k, st;
      bit                  first;
      for (int j = 0; j < n; j++) begin
         smp.push_back(SAMPLE_W'($urandom));
         e.s   = smp[j];
         e.sof = (j == 0);
         e.eof = (j == n - 1);
         e.tag = flag;
         eq.push_back(e);
      end
      pos = 0;
      left = n;
      first = 1'b1;
      while (left > 0) begin
         k  = (left >= SLOTS) ? SLOTS : left;
         st = SLOTS - k;
         for (int b = 0; b < WORD_W / 32; b++) w[b*32 +: 32] = $urandom;
         w[WORD_W-1 -: FLAG_W] = (left <= SLOTS) ? flag : '0;
         for (int s = 0; s < k; s++) w[(st + s) * SAMPLE_W +: SAMPLE_W] = smp[pos + s];
         wq.push_back(w);
         fq.push_back(first ? PIX_W'(n) : PIX_W'($urandom));
         pos  += k;
         left -= k;
         first = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      nrst = 1'b0;
      word_valid = 1'b0;
      sample_ready = 1'b0;
      err_clr = 1'b0;
      eq.delete();
      wq.delete();
      fq.delete();
      @(negedge clk);
      nrst = 1'b1;
   endtask

   // Drive queued words and consume samples, comparing every handshake
   task automatic run_stream(input int rdy_pct, input int gap_pct, input bit nobubble);
      int                  cyc = 0;
      int                  bubbles = 0;
      bit                  started = 1'b0;
      bit                  stalled = 1'b0;
      bit                  pend = 1'b0;
      logic [SAMPLE_W-1:0] held = '0;
      exp_t                e;
      while (eq.size() > 0 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         sample_ready = ($urandom_range(99) < rdy_pct);
         if (wq.size() > 0 && (pend || $urandom_range(99) >= gap_pct)) begin
            pend = 1'b1;
            word_valid = 1'b1;
            word_in = wq[0];
            frame_pixels = fq[0];
         end else begin
            word_valid = 1'b0;
         end
         #1;
         if (stalled) begin
            check("stall_valid", 32'(sample_valid), 32'd1);
            check("stall_hold", 32'(sample_out), 32'(held));
         end
         if (sample_valid) begin
            started = 1'b1;
            if (sample_ready) begin
               e = eq.pop_front();
               check("sample", 32'(sample_out), 32'(e.s));
               check("sof", 32'(sample_sof), 32'(e.sof));
               check("eof", 32'(sample_eof), 32'(e.eof));
               if (e.eof) check("frame_tag", 32'(frame_tag), 32'(e.tag));
            end
            stalled = !sample_ready;
            held = sample_out;
         end else begin
            stalled = 1'b0;
            if (started) bubbles++;
         end
         if (word_valid && word_ready) begin
            void'(wq.pop_front());
            void'(fq.pop_front());
            pend = 1'b0;
         end
      end
      check("timeout_left", 32'(eq.size()), 32'd0);
      @(negedge clk);
      word_valid = 1'b0;
      sample_ready = 1'b0;
      #1;
      check("idle_after", 32'(sample_valid), 32'd0);
      check("words_left", 32'(wq.size()), 32'd0);
      if (nobubble) check("no_bubble", 32'(bubbles), 32'd0);
   endtask

   initial begin
      nrst = 1'b0;
      frame_pixels = '0;
      word_in = '0;
      word_valid = 1'b0;
      sample_ready = 1'b0;
      err_clr = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_word_ready", 32'(word_ready), 32'd0);
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_sof", 32'(sample_sof), 32'd0);
      check("rst_eof", 32'(sample_eof), 32'd0);
      check("rst_tag", 32'(frame_tag), 32'd0);
      check("rst_err", 32'(err_flag), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      #1;
      check("post_rst_ready", 32'(word_ready), 32'd1);

      // 60-pixel frame: 25 + 25 + 10 (third word starts at slot 15)
      build_frame(60, 6'd5);
      run_stream(100, 0, 1'b1);
      check("err_60", 32'(err_flag), 32'd0);

      // 50-pixel frame (two full words) followed by a new frame
      build_frame(50, 6'd6);
      build_frame(30, 6'd7);
      run_stream(100, 0, 1'b1);

      // Random lengths, gaps and 50% backpressure
      for (int f = 0; f < 8; f++) begin
         build_frame($urandom_range(1, 120), FLAG_W'(8 + f));
         run_stream(50, 30, 1'b0);
      end
      check("err_rand", 32'(err_flag), 32'd0);

      // Reset in the middle of a frame at slot 7
      do_reset();
      build_frame(100, 6'd1);
      @(negedge clk);
      word_valid = 1'b1;
      word_in = wq[0];
      frame_pixels = fq[0];
      @(negedge clk);
      word_valid = 1'b0;
      sample_ready = 1'b1;
      repeat (7) @(negedge clk);
      sample_ready = 1'b0;
      #1;
      check("pre_rst_slot7", 32'(sample_out), 32'(eq[7].s));
      nrst = 1'b0;
      @(negedge clk);
      #1;
      check("mid_rst_valid", 32'(sample_valid), 32'd0);
      check("mid_rst_err", 32'(err_flag), 32'd0);
      check("mid_rst_ready", 32'(word_ready), 32'd0);
      nrst = 1'b1;
      eq.delete();
      wq.delete();
      fq.delete();
      build_frame(30, 6'd1);
      run_stream(100, 0, 1'b1);

      // Single-pixel frame: one sample from slot 24, sof and eof together
      do_reset();
      build_frame(1, 6'd1);
      run_stream(100, 0, 1'b0);
      check("err_fp1", 32'(err_flag), 32'd0);

`ifdef PISO_FLAG_CHECK_EN
      // Nonzero flag on a mid-frame word
      do_reset();
      build_frame(60, 6'd1);
      wq[0][WORD_W-1 -: FLAG_W] = 6'd3;
      run_stream(100, 0, 1'b0);
      check("err_midflag", 32'(err_flag), 32'd1);
      repeat (3) @(negedge clk);
      #1;
      check("err_sticky", 32'(err_flag), 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      check("err_cleared", 32'(err_flag), 32'd0);

      // Flag sequence 1, 2, 4: error on the third frame
      do_reset();
      build_frame(30, 6'd1);
      run_stream(100, 0, 1'b0);
      check("seq_f1", 32'(err_flag), 32'd0);
      build_frame(30, 6'd2);
      run_stream(100, 0, 1'b0);
      check("seq_f2", 32'(err_flag), 32'd0);
      build_frame(30, 6'd4);
      run_stream(100, 0, 1'b0);
      check("seq_f3", 32'(err_flag), 32'd1);
`else
      // Without the checker err_flag stays low even with bad flags and err_clr
      do_reset();
      build_frame(60, 6'd1);
      wq[0][WORD_W-1 -: FLAG_W] = 6'd3;
      err_clr = 1'b1;
      run_stream(100, 0, 1'b0);
      check("err_tied", 32'(err_flag), 32'd0);
      err_clr = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
